button_event_decoder: RTL and testbench

- Consumes the clean, debounced button level and converts it into single-cycle UI event pulses: press, release, long-press and auto-repeat.
- Sits between the button debouncers and the time/alarm-setting control logic. It lets the setting FSMs step values on a tap and scroll them while the button is held.
- Tick-based timing from a shared sample strobe, so hold thresholds are independent of the i_Clk frequency.

---
 rtl/button_event_decoder.sv | 179 +++++++++++++++++
 tb/tb_button_event_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Purpose:
//    Turns a debounced button level into single-cycle UI event pulses
//    (press, release, long-press, auto-repeat) for the time/alarm-setting
//    control logic. Hold thresholds are counted in i_Tick strobes, so they
//    do not depend on the i_Clk frequency.
//
// Configuration:
//    BTN_AUTO_REPEAT_EN - when defined, o_Repeat pulses every REPEAT_TICKS
//                         while the button stays held after o_Long. When
//                         undefined, o_Repeat is tied low, the repeat
//                         counting is removed and the LONG state simply
//                         waits for release with the counter frozen.
//
// Parameters:
//    LONG_TICKS   - ticks the button must be held before o_Long (>=1)
//    REPEAT_TICKS - ticks between o_Repeat pulses after o_Long (>=1)
//    CNT_W        - tick counter width, 2**CNT_W > max(LONG_TICKS, REPEAT_TICKS)
//
// Ports:
//    i_Clk      - system clock, rising edge
//    i_Rst_n    - asynchronous active-low reset
//    i_Tick     - one-cycle timing strobe, synchronous to i_Clk
//    i_Button   - debounced button level (1 = pressed), may be asynchronous
//    o_Press    - one-cycle pulse on press
//    o_Release  - one-cycle pulse on release
//    o_Long     - one-cycle pulse when the hold reaches LONG_TICKS
//    o_Repeat   - one-cycle pulse every REPEAT_TICKS after o_Long
//    o_Held     - level, high while the FSM is not idle
// ---------------------------------------------------------------------------
module button_event_decoder #(
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200,
   parameter int CNT_W        = 12
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_Tick,
   input  logic i_Button,
   output logic o_Press,
   output logic o_Release,
   output logic o_Long,
   output logic o_Repeat,
   output logic o_Held
);

   localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

   // Catch a counter too narrow to reach the larger threshold at elaboration.
   generate
      if ((2 ** CNT_W) <= MAX_TICKS) begin : g_cnt_w_too_small
         $error("button_event_decoder: CNT_W too small for the tick thresholds");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   logic             s1_q;
   logic             s2_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             long_q, long_d;
   logic             held_q, held_d;
`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
   logic             repeat_q, repeat_d;
`endif

   // Next-state and next-output logic. Release is tested before the tick
   // threshold in every held state, so a release coinciding with a
   // threshold tick yields only o_Release.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      repeat_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            // A tick in the press cycle is deliberately not counted.
            if (s2_q) begin
               state_d = ST_PRESSED;
               press_d = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_PRESSED: begin
            if (!s2_q) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
               cnt_d     = '0;
            end else if (i_Tick) begin
               if (cnt_q == LONG_LAST) begin
                  state_d = ST_LONG;
                  long_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_LONG: begin
            if (!s2_q) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
               cnt_d     = '0;
            end
`ifdef BTN_AUTO_REPEAT_EN
            else if (i_Tick) begin
               if (cnt_q == REPEAT_LAST) begin
                  repeat_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Registered from the next state so o_Held moves with o_Press/o_Release.
      held_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
      end else begin
         // Two-flop synchronizer; every decision uses s2_q.
         s1_q      <= i_Button;
         s2_q      <= s1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         held_q    <= held_d;
`ifdef BTN_AUTO_REPEAT_EN
         repeat_q  <= repeat_d;
`endif
      end
   end

   assign o_Press   = press_q;
   assign o_Release = release_q;
   assign o_Long    = long_q;
   assign o_Held    = held_q;
`ifdef BTN_AUTO_REPEAT_EN
   assign o_Repeat  = repeat_q;
`else
   assign o_Repeat  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_event_decoder
//
// Self-checking bench for button_event_decoder with LONG_TICKS=4,
// REPEAT_TICKS=2 and i_Tick high every cycle. Each scenario pushes the
// events it expects (kind + clock edge) onto a scoreboard queue before
// driving the button; the per-cycle observer pops and compares them.
// Repeat expectations follow BTN_AUTO_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_button_event_decoder;

   localparam int LT = 4;
   localparam int RT = 2;

   localparam logic [3:0] EV_PRESS   = 4'b1000;
   localparam logic [3:0] EV_RELEASE = 4'b0100;
   localparam logic [3:0] EV_LONG    = 4'b0010;
   localparam logic [3:0] EV_REPEAT  = 4'b0001;

   typedef struct {
      int         cyc;
      logic [3:0] kind;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic tick;
   logic button;
   logic o_press, o_release, o_long, o_repeat, o_held;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   logic exp_held = 1'b0;

   button_event_decoder #(
      .LONG_TICKS  (LT),
      .REPEAT_TICKS(RT),
      .CNT_W       (12)
   ) dut (
      .i_Clk    (clk),
      .i_Rst_n  (rst_n),
      .i_Tick   (tick),
      .i_Button (button),
      .o_Press  (o_press),
      .o_Release(o_release),
      .o_Long   (o_long),
      .o_Repeat (o_repeat),
      .o_Held   (o_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected events for one hold: button driven high just after edge ep,
   // low just after edge er. Press lands 3 edges later; long LT ticks after
   // press; repeats every RT after long; events stop at edge 'last'.
   function automatic void push_hold(input int ep, input int er,
                                     input bit with_rel, input int cut);
      ev_t e;
      int  p;
      int  last;
      p    = ep + 3;
      last = with_rel ? (er + 2) : cut;
      e.cyc = p; e.kind = EV_PRESS; exp_q.push_back(e);
      if (p + LT <= last) begin
         e.cyc = p + LT; e.kind = EV_LONG; exp_q.push_back(e);
      end
`ifdef BTN_AUTO_REPEAT_EN
      for (int t = p + LT + RT; t <= last; t += RT) begin
         e.cyc = t; e.kind = EV_REPEAT; exp_q.push_back(e);
      end
`endif
      if (with_rel) begin
         e.cyc = er + 3; e.kind = EV_RELEASE; exp_q.push_back(e);
      end
   endfunction

   // Advance n cycles, observing each cycle on the falling edge.
   task automatic step(input int n);
      ev_t        e;
      logic [3:0] obs;
      logic [3:0] exp_pulse;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event cyc=%0d observed none required kind=%b at cyc %0d",
                     cyc, exp_q[0].kind, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         obs = {o_press, o_release, o_long, o_repeat};
         if (!rst_n) begin
            exp_pulse = 4'b0000;
            exp_held  = 1'b0;
         end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e         = exp_q.pop_front();
            exp_pulse = e.kind;
            if (e.kind == EV_PRESS)   exp_held = 1'b1;
            if (e.kind == EV_RELEASE) exp_held = 1'b0;
         end else begin
            exp_pulse = 4'b0000;
         end
         checks++;
         if (obs !== exp_pulse) begin
            errors++;
            $display("FAIL pulses cyc=%0d observed=%b required=%b", cyc, obs, exp_pulse);
         end
         checks++;
         if (o_held !== exp_held) begin
            errors++;
            $display("FAIL held cyc=%0d observed=%b required=%b", cyc, o_held, exp_held);
         end
         if (obs != 4'b0000 || exp_pulse != 4'b0000)
            $display("cyc %0d rst_n=%b events(p,r,l,rep)=%b expected=%b held=%b",
                     cyc, rst_n, obs, exp_pulse, o_held);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL %s_drained observed %0d pending events required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      step(3);
      checks++;
      if ({o_press, o_release, o_long, o_repeat, o_held} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs observed=%b required=00000",
                  {o_press, o_release, o_long, o_repeat, o_held});
      end
      rst_n = 1'b1;
      step(4);
      check_drained("reset");
   endtask

   // Generic hold of 'len' cycles followed by idle time.
   task automatic run_hold(input string name, input int len);
      int ep;
      ep = cyc;
      push_hold(ep, ep + len, 1'b1, 0);
      $display("scenario %s: hold %0d cycles from cyc %0d", name, len, ep);
      button = 1'b1;
      step(len);
      button = 1'b0;
      step(8);
      check_drained(name);
   endtask

   task automatic test_press_repeat();       run_hold("press_repeat", 20); endtask
   task automatic test_short_tap();          run_hold("short_tap", 3);     endtask
   task automatic test_release_races_long(); run_hold("race_long", 4);     endtask
   task automatic test_long_boundary();      run_hold("long_edge", 5);     endtask
   task automatic test_long_hold();          run_hold("long_hold", 30);    endtask

   task automatic test_back_to_back();
      int ep;
      ep = cyc;
      push_hold(ep, ep + 6, 1'b1, 0);
      push_hold(ep + 8, ep + 14, 1'b1, 0);
      $display("scenario back_to_back from cyc %0d", ep);
      button = 1'b1;
      step(6);
      button = 1'b0;
      step(2);
      button = 1'b1;
      step(6);
      button = 1'b0;
      step(8);
      check_drained("back_to_back");
   endtask

   task automatic test_reset_mid_hold();
      int ep;
      int ey;
      ep = cyc;
      // Reset lands just after edge ep+10; pulses up to edge ep+9 are seen.
      push_hold(ep, 0, 1'b0, ep + 9);
      $display("scenario reset_mid_hold from cyc %0d", ep);
      button = 1'b1;
      step(10);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({o_press, o_release, o_long, o_repeat, o_held} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_mid_hold_outputs observed=%b required=00000",
                  {o_press, o_release, o_long, o_repeat, o_held});
      end
      step(3);
      ey = cyc;
      push_hold(ey, ey + 8, 1'b1, 0);
      rst_n = 1'b1;
      step(8);
      button = 1'b0;
      step(8);
      check_drained("reset_mid_hold");
   endtask

   initial begin
      rst_n  = 1'b0;
      tick   = 1'b1;
      button = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_press_repeat();
      test_short_tap();
      test_release_races_long();
      test_long_boundary();
      test_back_to_back();
      test_reset_mid_hold();
      test_long_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
